// File: rtl/catc_serial_loader.sv
// catc_serial_loader: assembles LSB-first serial frames into CATC {addr, data} commands and queues them in a FIFO.
// Define CATC_PARITY_EN to add a trailing odd-parity bit per frame with a CHECK state and sticky par_err.
module catc_serial_loader #(
    parameter int unsigned WORD_W     = 20,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              ser_valid,
    input  logic              ser_frame,
    output logic [WORD_W-1:0] cpu_addr,
    output logic [WORD_W-1:0] cpu_data,
    output logic              cpu_valid,
    input  logic              cpu_ready,
    input  logic              err_clr,
    output logic              overflow,
    output logic              par_err
);

    localparam int unsigned FLEN  = WORD_W + ADDR_W;
    localparam int unsigned CNT_W = $clog2(FLEN + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

`ifdef CATC_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t            state;
    logic [FLEN-1:0]   sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [FLEN-1:0]   cmd_c;
    logic              last_bit_c;
    logic              done_c;

    logic [FLEN-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_nxt_c;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_nxt_c;
    logic [FLEN-1:0]   head_c;
    logic              pop_c;
    logic              push_c;
    logic              full_c;
    logic              drop_c;

    // Frame completion decode; the command is taken from the shifter plus the bit on the wire.
`ifdef CATC_PARITY_EN
    logic bad_c;

    always_comb begin
        last_bit_c = (state == SHIFT) && ser_valid && !ser_frame &&
                     (bit_cnt == CNT_W'(FLEN - 1));
        cmd_c      = sr;
        done_c     = (state == CHECK) && ser_valid && !ser_frame && (^{sr, ser_in});
        bad_c      = (state == CHECK) && ser_valid && !ser_frame && !(^{sr, ser_in});
    end
`else
    always_comb begin
        last_bit_c = (state == SHIFT) && ser_valid && !ser_frame &&
                     (bit_cnt == CNT_W'(FLEN - 1));
        cmd_c      = sr | (FLEN'(ser_in) << (FLEN - 1));
        done_c     = last_bit_c;
    end
`endif

    // Receive FSM: a framed bit always restarts at bit 0, from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
        end else if (ser_valid) begin
            if (ser_frame) begin
                state   <= SHIFT;
                sr      <= FLEN'(ser_in);
                bit_cnt <= CNT_W'(1);
            end else begin
                case (state)
                    SHIFT: begin
                        sr <= sr | (FLEN'(ser_in) << bit_cnt);
                        if (last_bit_c) begin
`ifdef CATC_PARITY_EN
                            state   <= CHECK;
                            bit_cnt <= CNT_W'(FLEN);
`else
                            state   <= IDLE;
                            bit_cnt <= '0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
`ifdef CATC_PARITY_EN
                    CHECK: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // FIFO control; a full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        pop_c     = cpu_valid && cpu_ready;
        full_c    = (occ == OCC_W'(FIFO_DEPTH));
        push_c    = done_c && (!full_c || pop_c);
        drop_c    = done_c && full_c && !pop_c;
        rd_nxt_c  = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        occ_nxt_c = occ + OCC_W'(push_c) - OCC_W'(pop_c);
        head_c    = (push_c && (wr_ptr == rd_nxt_c)) ? cmd_c : mem[rd_nxt_c];
    end

    // Storage plus registered head presentation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            cpu_valid <= 1'b0;
            cpu_addr  <= '0;
            cpu_data  <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= cmd_c;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_nxt_c;
            occ       <= occ_nxt_c;
            cpu_valid <= (occ_nxt_c != '0);
            cpu_addr  <= WORD_W'(head_c[FLEN-1:WORD_W]);
            cpu_data  <= head_c[WORD_W-1:0];
        end
    end

    // Sticky flags; a set event wins over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (err_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef CATC_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (bad_c) begin
            par_err <= 1'b1;
        end else if (err_clr) begin
            par_err <= 1'b0;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_catc_serial_loader.sv
// Directed bench for catc_serial_loader: vector table of single frames plus hand-built FIFO, abort, reset and gap sequences.
module tb_catc_serial_loader;

    localparam int unsigned WORD_W     = 20;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef CATC_PARITY_EN
    localparam int NB = 25;
`else
    localparam int NB = 24;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              ser_in;
    logic              ser_valid;
    logic              ser_frame;
    logic [WORD_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_data;
    logic              cpu_valid;
    logic              cpu_ready;
    logic              err_clr;
    logic              overflow;
    logic              par_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    catc_serial_loader #(
        .WORD_W    (WORD_W),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ser_in   (ser_in),
        .ser_valid(ser_valid),
        .ser_frame(ser_frame),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_valid(cpu_valid),
        .cpu_ready(cpu_ready),
        .err_clr  (err_clr),
        .overflow (overflow),
        .par_err  (par_err)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [19:0] data;
        logic [19:0] exp_addr;
        logic [19:0] exp_data;
    } vec_t;

    vec_t vec[6];

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
        end
    endtask

    task automatic check_head(input string name, input logic [19:0] ea, input logic [19:0] ed);
        chk_b({name, ".valid"}, cpu_valid, 1'b1);
        chk_w({name, ".addr"}, cpu_addr, ea);
        chk_w({name, ".data"}, cpu_data, ed);
    endtask

    task automatic check_all_zero(input string name);
        chk_b({name, ".valid"}, cpu_valid, 1'b0);
        chk_w({name, ".addr"}, cpu_addr, 20'h0);
        chk_w({name, ".data"}, cpu_data, 20'h0);
        chk_b({name, ".ovf"}, overflow, 1'b0);
        chk_b({name, ".par"}, par_err, 1'b0);
    endtask

    task automatic pop_one();
        @(negedge clk);
        cpu_ready = 1'b1;
        @(posedge clk);
        #1;
        cpu_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic frm);
        @(negedge clk);
        ser_in    = b;
        ser_valid = 1'b1;
        ser_frame = frm;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        ser_frame = 1'b0;
    endtask

    // Returns 1 ns after the edge that captures the final bit of the frame.
    task automatic send_frame(input logic [3:0] a, input logic [19:0] d, input int gap_max,
                              input bit par_flip, input bit pop_last, input bit clr_last);
        logic [23:0] f;
        logic        b;
        bit          last;
        f = {a, d};
        for (int i = 0; i < NB; i++) begin
            if (i < 24) b = f[i];
            else        b = ~(^f) ^ par_flip;
            last = (i == NB - 1);
            @(negedge clk);
            ser_in    = b;
            ser_valid = 1'b1;
            ser_frame = (i == 0);
            if (last && pop_last) cpu_ready = 1'b1;
            if (last && clr_last) err_clr = 1'b1;
            @(posedge clk);
            #1;
            ser_valid = 1'b0;
            ser_frame = 1'b0;
            if (last) begin
                cpu_ready = 1'b0;
                err_clr   = 1'b0;
            end
            if (!last && gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(posedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] f;

        vec[0] = '{4'h1, 20'h00002, 20'h00001, 20'h00002};
        vec[1] = '{4'hA, 20'hABCDE, 20'h0000A, 20'hABCDE};
        vec[2] = '{4'hF, 20'h80000, 20'h0000F, 20'h80000};
        vec[3] = '{4'h0, 20'h00000, 20'h00000, 20'h00000};
        vec[4] = '{4'h5, 20'h5A5A5, 20'h00005, 20'h5A5A5};
        vec[5] = '{4'h8, 20'h00001, 20'h00008, 20'h00001};

        rst       = 1'b1;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        ser_frame = 1'b0;
        cpu_ready = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Unframed bits in IDLE are ignored
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk_b("idle_discard", cpu_valid, 1'b0);

        // First frame: valid right after the last-bit edge
        send_frame(4'h3, 20'h00001, 0, 1'b0, 1'b0, 1'b0);
        check_head("first", 20'h00003, 20'h00001);
        pop_one();
        chk_b("first_pop", cpu_valid, 1'b0);

        for (int i = 0; i < 6; i++) begin
            send_frame(vec[i].addr, vec[i].data, 0, 1'b0, 1'b0, 1'b0);
            check_head($sformatf("vec%0d", i), vec[i].exp_addr, vec[i].exp_data);
            pop_one();
            chk_b($sformatf("vec%0d_pop", i), cpu_valid, 1'b0);
        end

        // Five frames into a four-deep FIFO
        for (int i = 0; i < 5; i++) send_frame(vec[i].addr, vec[i].data, 0, 1'b0, 1'b0, 1'b0);
        chk_b("ovf_set", overflow, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check_head("hold", vec[0].exp_addr, vec[0].exp_data);
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("drain%0d", i), vec[i].exp_addr, vec[i].exp_data);
            pop_one();
        end
        chk_b("drain_empty", cpu_valid, 1'b0);
        pulse_clr();
        chk_b("ovf_clr", overflow, 1'b0);

        // Full FIFO with pop on the completion edge
        for (int i = 0; i < 4; i++) send_frame(vec[i].addr, vec[i].data, 0, 1'b0, 1'b0, 1'b0);
        send_frame(vec[4].addr, vec[4].data, 0, 1'b0, 1'b1, 1'b0);
        chk_b("fullpp_ovf", overflow, 1'b0);
        for (int i = 1; i < 5; i++) begin
            check_head($sformatf("fullpp%0d", i), vec[i].exp_addr, vec[i].exp_data);
            pop_one();
        end
        chk_b("fullpp_empty", cpu_valid, 1'b0);

        // Overflow set beats err_clr on the same edge
        for (int i = 0; i < 4; i++) send_frame(vec[i].addr, vec[i].data, 0, 1'b0, 1'b0, 1'b0);
        send_frame(vec[5].addr, vec[5].data, 0, 1'b0, 1'b0, 1'b1);
        chk_b("set_prio", overflow, 1'b1);
        repeat (4) pop_one();
        chk_b("prio_empty", cpu_valid, 1'b0);
        pulse_clr();
        chk_b("prio_clr", overflow, 1'b0);

        // Abort after 10 bits
        f = {4'h7, 20'h0F0F0};
        for (int i = 0; i < 10; i++) send_bit(f[i], i == 0);
        send_frame(4'h1, 20'h00002, 0, 1'b0, 1'b0, 1'b0);
        check_head("abort", 20'h00001, 20'h00002);
        pop_one();
        chk_b("abort_single", cpu_valid, 1'b0);

        // Reset mid-frame with two queued entries
        send_frame(vec[1].addr, vec[1].data, 0, 1'b0, 1'b0, 1'b0);
        send_frame(vec[2].addr, vec[2].data, 0, 1'b0, 1'b0, 1'b0);
        f = {4'h9, 20'h13579};
        for (int i = 0; i < 12; i++) send_bit(f[i], i == 0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 12; i < 24; i++) send_bit(f[i], 1'b0);
`ifdef CATC_PARITY_EN
        send_bit(1'b0, 1'b0);
`endif
        chk_b("rst_no_partial", cpu_valid, 1'b0);
        send_frame(4'h2, 20'h12345, 0, 1'b0, 1'b0, 1'b0);
        check_head("post_rst", 20'h00002, 20'h12345);
        pop_one();

        // Random gaps between bits
        send_frame(4'hF, 20'hFFFFF, 7, 1'b0, 1'b0, 1'b0);
        check_head("gaps", 20'h0000F, 20'hFFFFF);
        pop_one();
        chk_b("gaps_pop", cpu_valid, 1'b0);

`ifdef CATC_PARITY_EN
        send_frame(4'h0, 20'h00001, 0, 1'b1, 1'b0, 1'b0);
        chk_b("par_bad_flag", par_err, 1'b1);
        chk_b("par_bad_drop", cpu_valid, 1'b0);
        send_frame(4'h0, 20'h00001, 0, 1'b0, 1'b0, 1'b0);
        check_head("par_good", 20'h00000, 20'h00001);
        pop_one();
        pulse_clr();
        chk_b("par_clr", par_err, 1'b0);
`else
        chk_b("par_tied", par_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
